// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for the NxN weight-stationary systolic array: clear, weight load,
// activation stream, drain, result write-back. All outputs are registered.
module systolic_seq_ctrl #(
  parameter int N      = 4,
  parameter int K_W    = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear_all,
  input  logic [K_W-1:0]    k_len,
  output logic              busy,
  output logic              done,
  output logic              arr_clr,
  output logic              w_rd_en,
  output logic [ADDR_W-1:0] w_rd_addr,
  output logic              w_load,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_rd_addr,
  output logic              arr_en,
  output logic              res_wr_en,
  output logic [ADDR_W-1:0] res_wr_addr
);

  localparam int LAT = 2*N - 1;

  typedef enum logic [2:0] {IDLE, CLR, LOADW, STREAM, DRAIN} state_t;

  state_t            state;
  logic [K_W-1:0]    k_reg;
  // vld_pipe[i] marks an activation read i+1 cycles ago; the tap at LAT-1
  // registers into res_wr_en exactly LAT cycles after its arr_en cycle.
  logic [LAT-1:0]    vld_pipe;
  logic [ADDR_W-1:0] k_last;
  logic              last_w, last_a, last_r;

  assign k_last = ADDR_W'(k_reg) - ADDR_W'(1);
  assign last_w = (w_rd_addr == ADDR_W'(N-1));
  assign last_a = (a_rd_addr == k_last);
  assign last_r = res_wr_en && (res_wr_addr == k_last);

  always_ff @(posedge clk) begin
    if (rst || clear_all) begin
      state       <= IDLE;
      k_reg       <= '0;
      vld_pipe    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      arr_clr     <= !rst && clear_all;
      w_rd_en     <= 1'b0;
      w_rd_addr   <= '0;
      w_load      <= 1'b0;
      a_rd_en     <= 1'b0;
      a_rd_addr   <= '0;
      arr_en      <= 1'b0;
      res_wr_en   <= 1'b0;
      res_wr_addr <= '0;
    end else begin
      done        <= 1'b0;
      arr_clr     <= 1'b0;
      w_load      <= w_rd_en;
      arr_en      <= a_rd_en;
      vld_pipe    <= {vld_pipe[LAT-2:0], a_rd_en};
      res_wr_en   <= vld_pipe[LAT-1];
      res_wr_addr <= !vld_pipe[LAT-1] ? '0 :
                     res_wr_en ? res_wr_addr + ADDR_W'(1) : '0;
      case (state)
        IDLE: begin
          if (start && (k_len != '0)) begin
            state   <= CLR;
            busy    <= 1'b1;
            arr_clr <= 1'b1;
            k_reg   <= k_len;
          end
        end
        CLR: begin
          state     <= LOADW;
          w_rd_en   <= 1'b1;
          w_rd_addr <= '0;
        end
        LOADW: begin
          if (last_w) begin
            state     <= STREAM;
            w_rd_en   <= 1'b0;
            w_rd_addr <= '0;
            a_rd_en   <= 1'b1;
            a_rd_addr <= '0;
          end else begin
            w_rd_addr <= w_rd_addr + ADDR_W'(1);
          end
        end
        STREAM: begin
          if (last_a) begin
            state     <= DRAIN;
            a_rd_en   <= 1'b0;
            a_rd_addr <= '0;
          end else begin
            a_rd_addr <= a_rd_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          // arr_en keeps flushing zeros until the final result is written
          if (last_r) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
            arr_en <= 1'b0;
          end else begin
            arr_en <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
